// File: rtl/display_register_if.sv
// display_register_if
//   CPU-side register bus for the display_register peripheral.
//   master : the CPU (drives data/address/strobes, reads register/flag)
//   slave  : the peripheral
// Signals:
//   data         [31:0] CPU write data
//   address      [15:0] CPU read/write address
//   write_enable        write strobe, sampled on posedge clk
//   read_enable         read strobe (no side effects)
//   register     [31:0] read data, combinational
//   flag                1 = peripheral can accept a new value
interface display_register_if;
    logic [31:0] data;
    logic [15:0] address;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] register;
    logic        flag;

    modport master (
        output data, address, write_enable, read_enable,
        input  register, flag
    );

    modport slave (
        input  data, address, write_enable, read_enable,
        output register, flag
    );
endinterface

// File: rtl/display_register.sv
// display_register
//   Memory-mapped output peripheral: the CPU writes a 32-bit value to the
//   data register (DDR) and it is shown as 8 hex digits on a multiplexed,
//   active-low 7-segment display. A status register (DDSR) and the flag
//   output let software pace writes: a value is latched into the display
//   shadow at a frame boundary and held for one full frame before the
//   block accepts another write.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   display_register_if.slave (data, address, write_enable,
//         read_enable, register, flag)
//   an    [7:0] digit anodes, active-low, one-hot-low
//   seg   [6:0] segments {g,f,e,d,c,b,a}, active-low
// Build option:
//   DISP_BLANK_EN  when defined, leading zero digits are blanked (digit 0
//                  is never blanked); when undefined all digits are shown.
module display_register #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter logic [15:0] ADDR_DATA = 16'h8002,
    parameter logic [15:0] ADDR_STAT = 16'h8003
) (
    input  logic              clk,
    input  logic              rst,
    display_register_if.slave bus,
    output logic [7:0]        an,
    output logic [6:0]        seg
);
    localparam int unsigned   PW      = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SHOW
    } state_t;

    state_t        state;
    logic [31:0]   ddr;
    logic [31:0]   shadow;
    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic          tick;
    logic          frame_end;
    logic          busy;
    logic [3:0]    nibble;

    // Read strobe carries no side effects; it is accepted and ignored.
    logic unused_read;
    assign unused_read = bus.read_enable;

    assign tick      = (prescaler == PS_LAST);
    assign frame_end = tick && (idx == 3'd7);
    assign busy      = (state != IDLE);
    assign bus.flag  = ~busy;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Scan counters run in every state; the FSM only samples frame_end.
    // A write accepted on a boundary edge moves to PEND on that same edge,
    // so it naturally waits for the following boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ddr       <= '0;
            shadow    <= '0;
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.write_enable && bus.address == ADDR_DATA) begin
                        ddr   <= bus.data;
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (frame_end) begin
                        shadow <= ddr;
                        state  <= SHOW;
                    end
                end
                SHOW: begin
                    if (frame_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux reflects pre-edge state; reset forces zero.
    always_comb begin
        bus.register = '0;
        if (!rst) begin
            if (bus.address == ADDR_DATA) begin
                bus.register = ddr;
            end else if (bus.address == ADDR_STAT) begin
                bus.register = {31'b0, busy};
            end
        end
    end

    assign an     = ~(8'b1 << idx);
    assign nibble = shadow[{idx, 2'b00} +: 4];

`ifdef DISP_BLANK_EN
    logic [2:0] top_digit;

    // Index of the most significant nonzero nibble; 0 when shadow is 0.
    always_comb begin
        top_digit = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (shadow[4*i +: 4] != 4'h0) begin
                top_digit = 3'(i);
            end
        end
    end

    always_comb begin
        seg = hex7(nibble);
        if (idx > top_digit) begin
            seg = 7'h7F;
        end
    end
`else
    assign seg = hex7(nibble);
`endif

endmodule

// File: tb/tb_display_register.sv
// tb_display_register
//   Table-driven directed vectors, a few hand-written multi-cycle
//   sequences and randomized traffic, all checked against a time-based
//   reference model of the display register.
module tb_display_register;
    localparam int unsigned SD    = 4;
    localparam int          FRAME = 8 * SD;
    localparam logic [15:0] A_DATA = 16'h8002;
    localparam logic [15:0] A_STAT = 16'h8003;
`ifdef DISP_BLANK_EN
    localparam logic [6:0] ZHI = 7'h7F;
`else
    localparam logic [6:0] ZHI = 7'h40;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] an;
    logic [6:0] seg;

    display_register_if bus();

    display_register #(
        .SCAN_DIV (SD),
        .ADDR_DATA(A_DATA),
        .ADDR_STAT(A_STAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .an (an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    // Reference model: everything derives from the cycle count t since
    // the last reset edge plus the times at which a write takes effect.
    int          t         = 0;
    logic [31:0] m_ddr     = '0;
    logic [31:0] m_shadow  = '0;
    logic [31:0] m_next    = '0;
    int          shadow_at = -1;
    int          idle_at   = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int vectors     = 0;
    int miscompares = 0;

    function automatic int m_digit();
        return (t / SD) % 8;
    endfunction

    function automatic logic [7:0] m_an();
        logic [7:0] one;
        one = 8'h01;
        return ~(one << m_digit());
    endfunction

    function automatic logic [6:0] m_seg();
        int d;
        int nib;
        d   = m_digit();
        nib = int'((m_shadow >> (4 * d)) & 32'hF);
`ifdef DISP_BLANK_EN
        begin
            int top;
            top = 0;
            for (int k = 0; k < 8; k++) begin
                if (((m_shadow >> (4 * k)) & 32'hF) != 0) top = k;
            end
            if (d > top) return 7'h7F;
        end
`endif
        return hex_tab[nib];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (t=%0d)", name, got, exp, t);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model
    // (and against the given constants when chk=1), then advance the model.
    task automatic cycle(input logic r, input logic we, input logic re,
                         input logic [15:0] addr, input logic [31:0] d,
                         input logic chk, input logic [31:0] er, input logic ef,
                         input logic [7:0] ea, input logic [6:0] es, input string tag);
        logic        busy;
        logic [31:0] mreg;
        int          tb_edge;
        @(negedge clk);
        rst              = r;
        bus.write_enable = we;
        bus.read_enable  = re;
        bus.address      = addr;
        bus.data         = d;
        #1;
        busy = (t < idle_at);
        if (r)                    mreg = '0;
        else if (addr == A_DATA)  mreg = m_ddr;
        else if (addr == A_STAT)  mreg = {31'b0, busy};
        else                      mreg = '0;
        check({tag, "/reg"}, bus.register, mreg);
        if (chk) check({tag, "/reg_const"}, bus.register, er);
        if (!r) begin
            check({tag, "/flag"}, {31'b0, bus.flag}, {31'b0, !busy});
            check({tag, "/an"},   {24'b0, an},       {24'b0, m_an()});
            check({tag, "/seg"},  {25'b0, seg},      {25'b0, m_seg()});
            if (chk) begin
                check({tag, "/flag_const"}, {31'b0, bus.flag}, {31'b0, ef});
                check({tag, "/an_const"},   {24'b0, an},       {24'b0, ea});
                check({tag, "/seg_const"},  {25'b0, seg},      {25'b0, es});
            end
        end
        @(posedge clk);
        if (r) begin
            t         = 0;
            m_ddr     = '0;
            m_shadow  = '0;
            shadow_at = -1;
            idle_at   = 0;
        end else begin
            if (we && addr == A_DATA && !busy) begin
                m_ddr   = d;
                m_next  = d;
                tb_edge = (t / FRAME) * FRAME + FRAME - 1;
                if (tb_edge == t) tb_edge += FRAME;
                shadow_at = tb_edge + 1;
                idle_at   = tb_edge + 1 + FRAME;
            end
            t++;
            if (t == shadow_at) m_shadow = m_next;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 1'b1, A_DATA, 32'h0, 1'b0, '0, 1'b0, '0, '0, "idle");
    endtask

    typedef struct {
        logic        r;
        logic        we;
        logic [15:0] addr;
        logic [31:0] d;
        logic [31:0] er;
        logic        ef;
        logic [7:0]  ea;
        logic [6:0]  es;
    } vec_t;

    vec_t tbl [12];

    initial begin
        rst              = 1'b1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.address      = '0;
        bus.data         = '0;

        // Reset, idle reads, a write, dropped writes while busy.
        tbl[0]  = '{1'b1, 1'b0, A_DATA,  32'h0,        32'h0,        1'b1, 8'hFE, 7'h40};
        tbl[1]  = '{1'b1, 1'b0, A_STAT,  32'h0,        32'h0,        1'b1, 8'hFE, 7'h40};
        tbl[2]  = '{1'b0, 1'b0, A_STAT,  32'h0,        32'h0,        1'b1, 8'hFE, 7'h40};
        tbl[3]  = '{1'b0, 1'b0, A_DATA,  32'h0,        32'h0,        1'b1, 8'hFE, 7'h40};
        tbl[4]  = '{1'b0, 1'b0, 16'h1234, 32'h0,       32'h0,        1'b1, 8'hFE, 7'h40};
        tbl[5]  = '{1'b0, 1'b0, A_STAT,  32'h0,        32'h0,        1'b1, 8'hFE, 7'h40};
        tbl[6]  = '{1'b0, 1'b1, A_DATA,  32'h1234ABCD, 32'h0,        1'b1, 8'hFD, ZHI};
        tbl[7]  = '{1'b0, 1'b0, A_DATA,  32'h0,        32'h1234ABCD, 1'b0, 8'hFD, ZHI};
        tbl[8]  = '{1'b0, 1'b1, A_DATA,  32'hFFFFFFFF, 32'h1234ABCD, 1'b0, 8'hFD, ZHI};
        tbl[9]  = '{1'b0, 1'b1, A_STAT,  32'h5,        32'h1,        1'b0, 8'hFD, ZHI};
        tbl[10] = '{1'b0, 1'b0, A_DATA,  32'h0,        32'h1234ABCD, 1'b0, 8'hFB, ZHI};
        tbl[11] = '{1'b0, 1'b0, A_STAT,  32'h0,        32'h1,        1'b0, 8'hFB, ZHI};

        for (int i = 0; i < 12; i++)
            cycle(tbl[i].r, tbl[i].we, 1'b1, tbl[i].addr, tbl[i].d, 1'b1,
                  tbl[i].er, tbl[i].ef, tbl[i].ea, tbl[i].es, $sformatf("tbl%0d", i));

        // Shadow update at the first frame boundary, one full frame busy.
        idle(22);
        cycle(1'b0, 1'b0, 1'b1, A_STAT, 32'h0, 1'b1, 32'h1,        1'b0, 8'hFE, 7'h21, "show_d0");
        idle(27);
        cycle(1'b0, 1'b0, 1'b1, A_DATA, 32'h0, 1'b1, 32'h1234ABCD, 1'b0, 8'h7F, 7'h79, "show_d7");
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, A_STAT, 32'h0, 1'b1, 32'h1,        1'b0, 8'h7F, 7'h79, "last_busy");
        cycle(1'b0, 1'b0, 1'b1, A_STAT, 32'h0, 1'b1, 32'h0,        1'b1, 8'hFE, 7'h21, "idle_again");

        // Reset during PEND loses the pending value.
        cycle(1'b0, 1'b1, 1'b1, A_DATA, 32'h89, 1'b1, 32'h1234ABCD, 1'b1, 8'hFE, 7'h21, "write_89");
        cycle(1'b0, 1'b0, 1'b1, A_DATA, 32'h0,  1'b1, 32'h89,       1'b0, 8'hFE, 7'h21, "pend_89");
        cycle(1'b1, 1'b0, 1'b1, A_DATA, 32'h0,  1'b1, 32'h0,        1'b0, 8'hFE, 7'h21, "rst_pend");
        cycle(1'b0, 1'b0, 1'b1, A_DATA, 32'h0,  1'b1, 32'h0,        1'b1, 8'hFE, 7'h40, "post_rst");
        idle(31);
        cycle(1'b0, 1'b0, 1'b1, A_STAT, 32'h0,  1'b1, 32'h0,        1'b1, 8'hFE, 7'h40, "no_update");

        // Small value: leading-digit behaviour depends on DISP_BLANK_EN.
        idle(7);
        cycle(1'b0, 1'b1, 1'b0, A_DATA, 32'hA5, 1'b1, 32'h0, 1'b1, 8'hFB, ZHI, "write_a5");
        idle(23);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] ea;
            logic [6:0] es;
            ea = 8'h01;
            ea = ~(ea << k);
            es = (k == 0) ? 7'h12 : (k == 1) ? 7'h08 : ZHI;
            cycle(1'b0, 1'b0, 1'b1, A_STAT, 32'h0, 1'b1, 32'h1, 1'b0, ea, es,
                  $sformatf("a5_digit%0d", k));
            idle(3);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        we;
            logic [15:0] addr;
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0, 1:    addr = A_DATA;
                2:       addr = A_STAT;
                default: addr = 16'($urandom);
            endcase
            cycle(r, we, 1'($urandom), addr, $urandom, 1'b0, '0, 1'b0, '0, '0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
